// File: rtl/tt_vec_opacc_ctl_if.sv
// tt_vec_opacc_ctl_if: command, operand, preload, accumulator-drive and result signals of the outer-product controller
interface tt_vec_opacc_ctl_if #(
  parameter int VLEN = 256,
  parameter int XLEN = 64
);
  localparam int W = (VLEN / XLEN) * XLEN;
  logic cmd_valid, cmd_ready, cmd_load_c, cmd_issng_a, cmd_issng_b;
  logic [7:0] cmd_k;
  logic op_valid, op_ready;
  logic [W-1:0] op_a, op_b;
  logic cin_valid, cin_ready;
  logic [W-1:0] cin_data;
  logic en_ab, en_c, issng_a, issng_b;
  logic [W-1:0] vi_a, vi_b, vi_c, acc_c;
  logic res_valid, res_ready, res_last;
  logic [W-1:0] res_data;
  logic busy;
  modport slave (
    input  cmd_valid, cmd_k, cmd_load_c, cmd_issng_a, cmd_issng_b,
    input  op_valid, op_a, op_b, cin_valid, cin_data, acc_c, res_ready,
    output cmd_ready, op_ready, cin_ready, en_ab, en_c, issng_a, issng_b,
    output vi_a, vi_b, vi_c, res_valid, res_data, res_last, busy
  );
  modport master (
    output cmd_valid, cmd_k, cmd_load_c, cmd_issng_a, cmd_issng_b,
    output op_valid, op_a, op_b, cin_valid, cin_data, acc_c, res_ready,
    input  cmd_ready, op_ready, cin_ready, en_ab, en_c, issng_a, issng_b,
    input  vi_a, vi_b, vi_c, res_valid, res_data, res_last, busy
  );
endinterface

// File: rtl/tt_vec_opacc_ctl.sv
// tt_vec_opacc_ctl: sequences C preload/clear, k outer-product steps and FIFO row drain of a VL x ML accumulator
module tt_vec_opacc_ctl #(
  parameter int VLEN = 256,
  parameter int MLEN = 256,
  parameter int XLEN = 64
) (
  input logic clk,
  input logic reset,
  tt_vec_opacc_ctl_if.slave bus
);
  localparam int ML = MLEN / XLEN;
  localparam int W = (VLEN / XLEN) * XLEN;
  localparam int CW = $clog2(ML + 1);
  localparam logic [CW-1:0] ML_C = CW'(ML);
  localparam logic [CW-1:0] ML_M1 = CW'(ML - 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMP, DRAIN} state_t;
  state_t state, state_nx;
  logic [7:0] k_r, k_cnt;
  logic [CW-1:0] c_cnt;
  logic load_c_r, issng_a_r, issng_b_r, res_valid_r, res_last_r;
  logic cmd_rdy, cmd_acc, en_ab, en_c, last_c, res_hs, fin;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;

  // a drain pulse is allowed only when the result slot is empty or being emptied this cycle
  always_comb begin
    cmd_rdy = state == IDLE && !reset;
    cmd_acc = cmd_rdy && bus.cmd_valid;
    last_c = c_cnt == ML_M1;
    res_hs = res_valid_r && bus.res_ready;
    fin = res_hs && res_last_r;
    en_ab = state == COMP && bus.op_valid;
    en_c = state == LOAD ? (!load_c_r || bus.cin_valid) :
           state == DRAIN ? (c_cnt < ML_C && (!res_valid_r || bus.res_ready)) : 1'b0;
    state_nx = cmd_acc ? LOAD :
               (state == LOAD && en_c && last_c) ? (k_r != 8'd0 ? COMP : DRAIN) :
               (en_ab && k_cnt == k_r - 8'd1) ? DRAIN :
               fin ? IDLE : state;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      k_r <= '0;
      k_cnt <= '0;
      c_cnt <= '0;
      load_c_r <= 1'b0;
      issng_a_r <= 1'b0;
      issng_b_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_last_r <= 1'b0;
    end else begin
      if (cmd_acc) begin
        k_r <= bus.cmd_k;
        load_c_r <= bus.cmd_load_c;
        issng_a_r <= bus.cmd_issng_a;
        issng_b_r <= bus.cmd_issng_b;
        k_cnt <= '0;
        c_cnt <= '0;
      end
      if (en_c) c_cnt <= (state == LOAD && last_c) ? '0 : c_cnt + CW'(1);
      if (en_ab) k_cnt <= k_cnt + 8'd1;
      if (state == DRAIN && en_c) begin
        res_valid_r <= 1'b1;
        res_last_r <= last_c;
      end else if (res_hs) begin
        res_valid_r <= 1'b0;
        res_last_r <= 1'b0;
      end
      if (fin) begin
        issng_a_r <= 1'b0;
        issng_b_r <= 1'b0;
        load_c_r <= 1'b0;
        k_r <= '0;
      end
    end

  assign bus.cmd_ready = cmd_rdy;
  assign bus.cin_ready = state == LOAD && load_c_r;
  assign bus.op_ready = state == COMP;
  assign bus.en_ab = en_ab;
  assign bus.en_c = en_c;
  assign bus.issng_a = issng_a_r;
  assign bus.issng_b = issng_b_r;
  assign bus.vi_a = en_ab ? bus.op_a : W'(0);
  assign bus.vi_b = en_ab ? bus.op_b : W'(0);
  assign bus.vi_c = (state == LOAD && load_c_r && en_c) ? bus.cin_data : W'(0);
  assign bus.res_valid = res_valid_r;
  assign bus.res_last = res_last_r;
  assign bus.res_data = res_valid_r ? bus.acc_c : W'(0);
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_tt_vec_opacc_ctl.sv
// tb_tt_vec_opacc_ctl: drives commands/operands/preload rows against an accumulator model and checks drained rows
module tb_tt_vec_opacc_ctl;
  localparam int VLEN = 256, MLEN = 256, XLEN = 64;
  localparam int VL = VLEN / XLEN, ML = MLEN / XLEN, W = VL * XLEN;
  logic clk = 1'b0, reset;
  logic [W-1:0] acc [ML];
  logic [W-1:0] c_rows [ML];
  logic [W-1:0] a_ops [$], b_ops [$], got_q [$];
  bit last_q [$];
  int nab, nc, viol, acc_cyc, cmp, err;
  bit done, rdy_at_last, ldc_m;

  tt_vec_opacc_ctl_if #(.VLEN(VLEN), .XLEN(XLEN)) bus ();
  tt_vec_opacc_ctl #(.VLEN(VLEN), .MLEN(MLEN), .XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // accumulator: en_c shifts rows (oldest out on acc_c), en_ab adds a (x) b into every column
  always @(posedge clk) begin
    if (bus.en_c) begin
      bus.acc_c <= acc[0];
      for (int j = 0; j < ML - 1; j++) acc[j] <= acc[j+1];
      acc[ML-1] <= bus.vi_c;
    end else if (bus.en_ab)
      for (int j = 0; j < ML; j++)
        for (int i = 0; i < VL; i++)
          acc[j][i*XLEN +: XLEN] <= acc[j][i*XLEN +: XLEN] + bus.vi_a[i*XLEN +: XLEN] * bus.vi_b[j*XLEN +: XLEN];
  end

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // expected row j: initial C column (or zero) plus the sum of all outer-product steps, lane-wise mod 2^XLEN
  function automatic logic [W-1:0] model_row(input int j);
    logic [W-1:0] r;
    r = ldc_m ? c_rows[j] : '0;
    foreach (a_ops[t])
      for (int i = 0; i < VL; i++)
        r[i*XLEN +: XLEN] = r[i*XLEN +: XLEN] + XLEN'(a_ops[t][i*XLEN +: XLEN] * b_ops[t][j*XLEN +: XLEN]);
    return r;
  endfunction

  function automatic void fill_rand(input int k);
    a_ops.delete();
    b_ops.delete();
    for (int i = 0; i < ML; i++) c_rows[i] = rnd_w();
    for (int t = 0; t < k; t++) begin
      a_ops.push_back(rnd_w());
      b_ops.push_back(rnd_w());
    end
  endfunction

  task automatic run_txn(input bit ldc, input bit ia, input bit ib, input int gap, input int rmode, input bit hold, input bit align);
    int ci, oi, gcnt, k;
    bit acc_d, prev_stall;
    logic [W-1:0] prev_data;
    if (align) begin
      @(posedge clk);
      #1;
    end
    got_q.delete();
    last_q.delete();
    nab = 0; nc = 0; viol = 0; acc_cyc = -1; done = 0; rdy_at_last = 1; ldc_m = ldc;
    ci = 0; oi = 0; gcnt = 0; acc_d = 0; prev_stall = 0; prev_data = '0;
    k = a_ops.size();
    bus.cmd_valid = 1; bus.cmd_k = 8'(k); bus.cmd_load_c = ldc; bus.cmd_issng_a = ia; bus.cmd_issng_b = ib;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      bus.cin_valid = ldc && ci < ML && $urandom_range(0, 3) != 0;
      bus.cin_data = ci < ML ? c_rows[ci] : '0;
      bus.op_valid = oi < k && gcnt == 0 && (gap > 0 || $urandom_range(0, 2) != 0);
      bus.op_a = oi < k ? a_ops[oi] : '0;
      bus.op_b = oi < k ? b_ops[oi] : '0;
      bus.res_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.en_ab && bus.en_c) viol++;
      if (bus.en_c && bus.res_valid && !bus.res_ready) viol++;
      if (prev_stall && bus.res_data !== prev_data) viol++;
      if (acc_d && (bus.issng_a !== ia || bus.issng_b !== ib || bus.busy !== 1'b1)) viol++;
      if (!bus.busy && (bus.vi_a !== '0 || bus.vi_b !== '0 || bus.vi_c !== '0 || bus.en_c || bus.en_ab)) viol++;
      if (bus.en_c && nc < ML && bus.vi_c !== (ldc ? c_rows[nc] : '0)) viol++;
      if (bus.en_c && nc >= ML && bus.vi_c !== '0) viol++;
      if (ldc && nc < ML && bus.en_c !== (bus.cin_valid && bus.cin_ready)) viol++;
      if (bus.en_ab) nab++;
      if (bus.en_c) nc++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (acc_d) viol++;
        else begin
          acc_d = 1;
          acc_cyc = cyc;
        end
      end
      if (bus.cin_valid && bus.cin_ready) ci++;
      if (bus.op_valid && bus.op_ready) begin
        oi++;
        gcnt = gap;
      end else if (gcnt > 0) gcnt--;
      if (bus.res_valid && bus.res_ready) begin
        got_q.push_back(bus.res_data);
        last_q.push_back(bus.res_last);
        if (bus.res_last) begin
          done = 1;
          rdy_at_last = bus.cmd_ready;
        end
      end
      prev_stall = bus.res_valid && !bus.res_ready;
      prev_data = bus.res_data;
      @(posedge clk);
      #1;
      if (acc_d && !hold) bus.cmd_valid = 0;
    end
    bus.cin_valid = 0; bus.op_valid = 0; bus.res_ready = 0;
  endtask

  task automatic test_reset();
    #12;
    cmp++;
    if ({bus.cmd_ready, bus.en_ab, bus.en_c, bus.res_valid, bus.res_last, bus.busy, bus.issng_a, bus.issng_b} !== 8'b0 || bus.vi_c !== '0) begin
      err++;
      $display("FAIL reset_outputs: got ready=%b en_ab=%b en_c=%b rv=%b busy=%b want all 0", bus.cmd_ready, bus.en_ab, bus.en_c, bus.res_valid, bus.busy);
    end
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      err++;
      $display("FAIL reset_release: got cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_clear_k1();
    a_ops.delete();
    b_ops.delete();
    a_ops.push_back({VL{XLEN'(2)}});
    b_ops.push_back({VL{XLEN'(3)}});
    run_txn(0, 0, 0, 0, 0, 0, 1);
    cmp++;
    if (done !== 1'b1 || nab !== 1 || nc !== 2 * ML || viol !== 0) begin
      err++;
      $display("FAIL clear_k1_counts: got done=%0d en_ab=%0d en_c=%0d viol=%0d want 1 1 %0d 0", done, nab, nc, viol, 2 * ML);
    end
    for (int j = 0; j < ML; j++) begin
      cmp++;
      if (j >= got_q.size() || got_q[j] !== {VL{XLEN'(6)}} || last_q[j] !== (j == ML - 1)) begin
        err++;
        $display("FAIL clear_k1_row%0d: got %h last=%b want all lanes 6 last=%b", j, got_q[j], last_q[j], j == ML - 1);
      end
    end
  endtask

  task automatic test_preload_k0();
    a_ops.delete();
    b_ops.delete();
    for (int j = 0; j < ML; j++) c_rows[j] = {VL{XLEN'(j + 1)}};
    run_txn(1, 0, 0, 0, 0, 0, 1);
    cmp++;
    if (done !== 1'b1 || nab !== 0 || viol !== 0) begin
      err++;
      $display("FAIL preload_k0_counts: got done=%0d en_ab=%0d viol=%0d want 1 0 0", done, nab, viol);
    end
    for (int j = 0; j < ML; j++) begin
      cmp++;
      if (j >= got_q.size() || got_q[j] !== {VL{XLEN'(j + 1)}}) begin
        err++;
        $display("FAIL preload_k0_row%0d: got %h want all lanes %0d", j, got_q[j], j + 1);
      end
    end
  endtask

  task automatic test_drain_stall();
    fill_rand(2);
    run_txn(1, 0, 1, 0, 1, 0, 1);
    cmp++;
    if (done !== 1'b1 || nc - ML !== ML || viol !== 0 || got_q.size() !== ML) begin
      err++;
      $display("FAIL drain_stall: got done=%0d drain_en_c=%0d viol=%0d rows=%0d want 1 %0d 0 %0d", done, nc - ML, viol, got_q.size(), ML, ML);
    end
    for (int j = 0; j < ML; j++) begin
      cmp++;
      if (j >= got_q.size() || got_q[j] !== model_row(j)) begin
        err++;
        $display("FAIL drain_stall_row%0d: got %h want %h", j, got_q[j], model_row(j));
      end
    end
  endtask

  task automatic test_gapped_issng();
    fill_rand(3);
    run_txn(1'($urandom_range(0, 1)), 1, 0, 2, 0, 0, 1);
    cmp++;
    if (done !== 1'b1 || nab !== 3 || viol !== 0) begin
      err++;
      $display("FAIL gapped_issng: got done=%0d en_ab=%0d viol=%0d want 1 3 0", done, nab, viol);
    end
    cmp++;
    if (got_q.size() !== ML || got_q[ML-1] !== model_row(ML - 1) || got_q[0] !== model_row(0)) begin
      err++;
      $display("FAIL gapped_rows: got rows=%0d last=%h want %0d %h", got_q.size(), got_q[ML-1], ML, model_row(ML - 1));
    end
    @(negedge clk);
    cmp++;
    if (bus.issng_a !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      err++;
      $display("FAIL issng_idle: got issng_a=%b busy=%b ready=%b want 0 0 1", bus.issng_a, bus.busy, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    fill_rand(2);
    run_txn(0, 1, 1, 0, 2, 1, 1);
    cmp++;
    if (done !== 1'b1 || rdy_at_last !== 1'b0 || viol !== 0) begin
      err++;
      $display("FAIL b2b_first: got done=%0d ready_at_last=%b viol=%0d want 1 0 0", done, rdy_at_last, viol);
    end
    fill_rand(1);
    run_txn(1, 0, 0, 0, 0, 0, 0);
    cmp++;
    if (acc_cyc !== 0 || done !== 1'b1) begin
      err++;
      $display("FAIL b2b_accept: got accept_cycle=%0d done=%0d want 0 1", acc_cyc, done);
    end
    cmp++;
    if (got_q.size() !== ML || got_q[1] !== model_row(1)) begin
      err++;
      $display("FAIL b2b_rows: got rows=%0d row1=%h want %0d %h", got_q.size(), got_q[1], ML, model_row(1));
    end
  endtask

  task automatic test_random(input int n);
    for (int r = 0; r < n; r++) begin
      fill_rand($urandom_range(0, 6));
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 1), 2, 0, 1);
      cmp++;
      if (done !== 1'b1 || acc_cyc !== 0 || nab !== a_ops.size() || nc !== 2 * ML || viol !== 0) begin
        err++;
        $display("FAIL random%0d_counts: got done=%0d acc=%0d en_ab=%0d en_c=%0d viol=%0d want 1 0 %0d %0d 0", r, done, acc_cyc, nab, nc, viol, a_ops.size(), 2 * ML);
      end
      for (int j = 0; j < ML; j++) begin
        cmp++;
        if (j >= got_q.size() || got_q[j] !== model_row(j) || last_q[j] !== (j == ML - 1)) begin
          err++;
          $display("FAIL random%0d_row%0d: got %h last=%b want %h", r, j, got_q[j], last_q[j], model_row(j));
        end
      end
    end
  endtask

  task automatic test_reset_mid_comp();
    int n = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1; bus.cmd_k = 8'd5; bus.cmd_load_c = 0; bus.cmd_issng_a = 1; bus.cmd_issng_b = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 0; bus.op_valid = 1; bus.op_a = rnd_w(); bus.op_b = rnd_w();
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (bus.op_valid && bus.op_ready) n++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cmp++;
    if (n !== 2 || bus.en_ab !== 1'b1) begin
      err++;
      $display("FAIL midcomp_setup: got steps=%0d en_ab=%b want 2 1", n, bus.en_ab);
    end
    #1 reset = 1;
    #1;
    cmp++;
    if ({bus.en_ab, bus.en_c, bus.res_valid, bus.busy, bus.cmd_ready, bus.issng_a} !== 6'b0) begin
      err++;
      $display("FAIL midcomp_reset: got en_ab=%b en_c=%b rv=%b busy=%b ready=%b issng_a=%b want 0", bus.en_ab, bus.en_c, bus.res_valid, bus.busy, bus.cmd_ready, bus.issng_a);
    end
    @(posedge clk);
    #1 reset = 0;
    bus.op_valid = 0;
    @(negedge clk);
    cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      err++;
      $display("FAIL midcomp_release: got cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
    end
  endtask

  initial begin
    reset = 1;
    bus.cmd_valid = 0; bus.cmd_k = 0; bus.cmd_load_c = 0; bus.cmd_issng_a = 0; bus.cmd_issng_b = 0;
    bus.op_valid = 0; bus.op_a = '0; bus.op_b = '0;
    bus.cin_valid = 0; bus.cin_data = '0; bus.res_ready = 0;
    test_reset();
    test_clear_k1();
    test_preload_k0();
    test_drain_stall();
    test_gapped_issng();
    test_back_to_back();
    test_random(6);
    test_reset_mid_comp();
    test_random(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/tt_vec_opacc_ctl.md
TT_VEC_OPACC_CTL -- requirements
Module: tt_vec_opacc_ctl

Interface
REQ-001 SHALL have parameter VLEN, default 256, vector register width in bits.
REQ-002 SHALL have parameter MLEN, default 256, accumulator column span in bits.
REQ-003 SHALL have parameter XLEN, default 64, element width; derived VL=VLEN/XLEN rows, ML=MLEN/XLEN columns.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1  command handshake.
REQ-007 SHALL have ports cmd_k in 8 (outer-product step count, 0 legal), cmd_load_c in 1 (1=preload C, 0=clear), cmd_issng_a in 1, cmd_issng_b in 1.
REQ-008 SHALL have ports op_valid in 1, op_ready out 1, op_a in VL*XLEN, op_b in VL*XLEN  operand stream.
REQ-009 SHALL have ports cin_valid in 1, cin_ready out 1, cin_data in VL*XLEN  C-row preload stream.
REQ-010 SHALL have ports en_ab out 1, en_c out 1, issng_a out 1, issng_b out 1, vi_a out VL*XLEN, vi_b out VL*XLEN, vi_c out VL*XLEN  accumulator drive.
REQ-011 SHALL have port acc_c  in  VL*XLEN  accumulator shifted-out row (registered by accumulator on en_c).
REQ-012 SHALL have ports res_valid out 1, res_ready in 1, res_data out VL*XLEN, res_last out 1  result row stream.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, COMP, DRAIN.
REQ-015 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready register k, load_c, issng_a, issng_b and enter LOAD.
REQ-016 SHALL drive issng_a/issng_b from the registered command values, held constant from the cycle after acceptance until return to IDLE.
REQ-017 SHALL in LOAD issue exactly ML en_c pulses: if load_c=1, en_c=cin_ready=cin_valid and vi_c=cin_data; if load_c=0, en_c=1 every cycle and vi_c=0.
REQ-018 SHALL ignore acc_c rows shifted out during LOAD (no res_valid).
REQ-019 SHALL after the ML-th LOAD pulse enter COMP if k>0, else DRAIN.
REQ-020 SHALL in COMP drive en_ab=op_ready=op_valid, vi_a=op_a, vi_b=op_b combinationally; count handshakes; enter DRAIN on the k-th.
REQ-021 SHALL never assert en_ab and en_c in the same cycle; en_ab=0 outside COMP, en_c=0 outside LOAD/DRAIN.
REQ-022 SHALL in DRAIN drive vi_c=0 and pulse en_c when (!res_valid || res_ready) and fewer than ML pulses issued.
REQ-023 SHALL set res_valid at the edge ending each DRAIN en_c cycle; res_data=acc_c combinationally, stable while res_valid && !res_ready.
REQ-024 SHALL clear res_valid on a handshake with no same-cycle en_c; a handshake with en_c keeps res_valid=1 (one row/cycle at res_ready=1).
REQ-025 SHALL assert res_last with the ML-th result row; its handshake returns the block to IDLE.
REQ-026 SHALL deliver rows first-in first-out: first C row loaded is first row drained.
REQ-027 SHALL accept a new command no earlier than the cycle after the final result handshake.
REQ-028 SHALL keep vi_a, vi_b, vi_c at 0 when not actively driving.

Reset
REQ-029 SHALL on reset force IDLE and all outputs to 0 (cmd_ready=1 after deassertion), counters cleared, regardless of state.
REQ-030 SHALL treat accumulator contents as undefined after reset; every command initializes via LOAD.

Verification
REQ-031 SHALL cover: reset asserted mid-COMP (k=5, 2 steps done) -> en_ab, en_c, res_valid=0 immediately; cmd_ready=1 cycle after release.
REQ-032 SHALL cover: load_c=0, k=1, op_a lanes=2, op_b lanes=3, unsigned -> 4 clear pulses, 1 en_ab, 4 rows each lane=6, res_last on row 4.
REQ-033 SHALL cover: load_c=1, k=0, C rows lane values 1,2,3,4 -> no en_ab, result rows 1,2,3,4 in order.
REQ-034 SHALL cover: res_ready toggled 1,0,0,1,... in DRAIN -> exactly 4 en_c pulses, each only on res_valid=0 or handshake cycles, res_data stable while stalled.
REQ-035 SHALL cover: k=3, op_valid with 2-cycle gaps, cmd_issng_a=1 -> exactly 3 en_ab pulses, issng_a=1 through DRAIN, 0 back in IDLE.
REQ-036 SHALL cover: cmd_valid held high across final handshake -> accepted exactly one cycle after res_last handshake.
